// File: rtl/serial_tx_shifter.sv
// -----------------------------------------------------------------------------
// serial_tx_shifter
//
// Parallel-in, serial-out frame transmitter. This is the send side of the
// serial link. A WIDTH-bit word is captured on a load request and sent on
// a single line in this order:
//   start bit (0), data LSB-first, optional parity bit, stop bit (1).
//
// Parameters
//   WIDTH  : data bits per frame, 2..16
//   PARITY : 0 = none, 1 = even, 2 = odd. Any other value behaves as 0.
//
// Ports
//   clk    : single clock; all state updates on the rising edge
//   rst_n  : asynchronous, active-low reset; aborts any frame in flight
//   load   : transmit request; accepted only on an edge where busy = 0
//   din    : word to send; sampled only on the accepting edge
//   sout   : serial line; idles high
//   busy   : high from the cycle after acceptance through the stop-bit cycle
//   done   : one-cycle pulse, high during the stop-bit cycle
//
// Every output is decoded from registered state only. There is no
// combinational path from load or din to any output.
// -----------------------------------------------------------------------------
module serial_tx_shifter #(
  parameter int WIDTH  = 8,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Unsupported PARITY codes fall back to "no parity bit".
  localparam logic HAS_PAR = (PARITY == 1) || (PARITY == 2);
  localparam logic ODD_PAR = (PARITY == 2);

  // The count value during the final data bit. DATA is left after this count.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [WIDTH-1:0] shreg;    // outgoing data; bit 0 is on the line in DATA
  logic [CNT_W-1:0] bit_cnt;  // index of the data bit currently on the line
  logic             par_acc;  // XOR of the data bits already transmitted

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default on
  // entry. Without it, any path that skips the assignment infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (bit_cnt == LAST_CNT) state_nxt = HAS_PAR ? PAR : STOP;
      PAR:     state_nxt = STOP;
      STOP:    state_nxt = IDLE;   // load in STOP is ignored; IDLE always follows
      default: state_nxt = IDLE;   // recover from any unused encoding
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. This keeps every
  // register sampling the values from before the edge, whatever order the
  // blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, bit counter, parity accumulator
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset along with the state. The outputs
  // already depend only on state, so this is not needed for correct line
  // behaviour. It makes the post-reset contents deterministic, which matters
  // to anything that probes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_acc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The accepting edge. Counter and parity are cleared as START is
          // entered, so each frame starts from a known state.
          if (load) begin
            shreg   <= din;
            bit_cnt <= '0;
            par_acc <= 1'b0;
          end
        end
        DATA: begin
          shreg   <= shreg >> 1;
          par_acc <= par_acc ^ shreg[0];
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        default: ;  // START, PAR and STOP hold the datapath
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode, from state only
  // ---------------------------------------------------------------------------
  // Reset forces state to IDLE asynchronously. The line therefore goes high
  // and busy/done drop at once, with no clock edge required.
  always_comb begin
    sout = 1'b1;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      START: begin
        sout = 1'b0;
        busy = 1'b1;
      end
      DATA: begin
        sout = shreg[0];
        busy = 1'b1;
      end
      PAR: begin
        // par_acc holds the XOR of all data bits here. Even parity sends it
        // unchanged and odd parity sends it inverted.
        sout = par_acc ^ ODD_PAR;
        busy = 1'b1;
      end
      STOP: begin
        sout = 1'b1;
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;  // IDLE and unused codes: line high, not busy
    endcase
  end

endmodule
